// File: rtl/line_clear_ctrl.sv
// Post-lock board sweep: removes full rows bottom-up, compacts survivors downward, zero-fills the top.
// Optional scoring enabled by defining LINE_CLEAR_SCORE_EN; otherwise score is tied to zero.
module line_clear_ctrl #(
    parameter int unsigned ROWS = 20,
    parameter int unsigned COLS = 10,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            refresh,
    output logic            refresh_done,
    output logic            busy,
    output logic [AW-1:0]   ram_addr,
    output logic            ram_wr_en,
    output logic [COLS-1:0] ram_wr_data,
    input  logic [COLS-1:0] ram_rd_data,
    output logic [AW:0]     lines_last,
    output logic [15:0]     lines_total,
    output logic [15:0]     score
);
    localparam int unsigned NW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CHK, S_ZFILL, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   r, r_nxt, w, w_nxt, z, z_nxt;
    logic [NW-1:0]   n, n_nxt;
    logic            row_full;
    logic            enter_done;

    assign row_full   = &ram_rd_data;
    assign enter_done = (state_nxt == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            r            <= '0;
            w            <= '0;
            z            <= '0;
            n            <= '0;
            busy         <= 1'b0;
            refresh_done <= 1'b0;
        end else begin
            state        <= state_nxt;
            r            <= r_nxt;
            w            <= w_nxt;
            z            <= z_nxt;
            n            <= n_nxt;
            busy         <= (state_nxt != S_IDLE);
            refresh_done <= enter_done;
        end
    end

    // Next state, pointer updates and the combinational RAM port decode
    always_comb begin
        state_nxt   = state;
        r_nxt       = r;
        w_nxt       = w;
        z_nxt       = z;
        n_nxt       = n;
        ram_addr    = '0;
        ram_wr_en   = 1'b0;
        ram_wr_data = '0;
        case (state)
            S_IDLE: begin
                if (refresh) begin
                    r_nxt     = AW'(ROWS - 1);
                    w_nxt     = AW'(ROWS - 1);
                    n_nxt     = '0;
                    state_nxt = S_RD;
                end
            end
            S_RD: begin
                ram_addr  = r;
                state_nxt = S_CHK;
            end
            S_CHK: begin
                ram_addr = r;
                if (row_full) begin
                    n_nxt = n + NW'(1);
                end else begin
                    if (w != r) begin
                        ram_addr    = w;
                        ram_wr_en   = 1'b1;
                        ram_wr_data = ram_rd_data;
                    end
                    // w only reaches 0 on the final row, where it is never used again
                    if (w != '0) w_nxt = w - AW'(1);
                end
                if (r == '0) begin
                    if (n_nxt != '0) begin
                        z_nxt     = AW'(n_nxt - NW'(1));
                        state_nxt = S_ZFILL;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end else begin
                    r_nxt     = r - AW'(1);
                    state_nxt = S_RD;
                end
            end
            S_ZFILL: begin
                ram_addr  = z;
                ram_wr_en = 1'b1;
                if (z == '0) state_nxt = S_DONE;
                else         z_nxt     = z - AW'(1);
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Clear statistics, captured on the edge entering DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lines_last  <= '0;
            lines_total <= '0;
        end else if (enter_done) begin
            lines_last  <= n_nxt;
            lines_total <= lines_total + 16'(n_nxt);
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] score_inc;
    logic [16:0] score_sum;

    always_comb begin
        score_inc = 16'd0;
        case (n_nxt)
            NW'(0):  score_inc = 16'd0;
            NW'(1):  score_inc = 16'd1;
            NW'(2):  score_inc = 16'd3;
            NW'(3):  score_inc = 16'd5;
            default: score_inc = 16'd8;
        endcase
    end

    assign score_sum = 17'(score) + 17'(score_inc);

    // Saturating accumulate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score <= '0;
        end else if (enter_done) begin
            score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Self-checking bench for line_clear_ctrl: RAM model, board-level reference model, random and directed boards.
module tb_line_clear_ctrl;
    localparam int unsigned ROWS = 20;
    localparam int unsigned COLS = 10;
    localparam int unsigned AW   = 5;
    localparam int unsigned MAXC = 3 * ROWS + 4;

    typedef logic [COLS-1:0] row_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          refresh;
    logic          refresh_done;
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic          ram_wr_en;
    row_t          ram_wr_data;
    row_t          ram_rd_data;
    logic [AW:0]   lines_last;
    logic [15:0]   lines_total;
    logic [15:0]   score;

    line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .refresh      (refresh),
        .refresh_done (refresh_done),
        .busy         (busy),
        .ram_addr     (ram_addr),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_data  (ram_wr_data),
        .ram_rd_data  (ram_rd_data),
        .lines_last   (lines_last),
        .lines_total  (lines_total),
        .score        (score)
    );

    always #5 clk = ~clk;

    // Board RAM with synchronous read and a bulk preload port
    row_t mem [ROWS];
    row_t init_board [ROWS];
    row_t rd_q;
    logic load;

    always @(posedge clk) begin
        if (load) mem <= init_board;
        else if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
        rd_q <= mem[ram_addr];
    end
    assign ram_rd_data = rd_q;

    int vectors = 0;
    int errors  = 0;

    row_t exp_board [ROWS];
    int   exp_n, exp_done;
    logic exp_wen   [MAXC];
    int   exp_waddr [MAXC];
    row_t exp_wdata [MAXC];
    int   m_total = 0;
    int   m_score = 0;
    int   done_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: what the board and the write trace must look like, from init_board
    task automatic build_model();
        int m;
        row_t full;
        full  = '1;
        exp_n = 0;
        m     = 0;
        for (int k = 0; k < int'(MAXC); k++) begin
            exp_wen[k] = 1'b0; exp_waddr[k] = 0; exp_wdata[k] = '0;
        end
        for (int j = 0; j < int'(ROWS); j++) begin
            int src, dst;
            src = int'(ROWS) - 1 - j;
            if (init_board[src] == full) begin
                exp_n++;
            end else begin
                dst = int'(ROWS) - 1 - m;
                exp_board[dst] = init_board[src];
                if (dst != src) begin
                    exp_wen[2*j+2]   = 1'b1;
                    exp_waddr[2*j+2] = dst;
                    exp_wdata[2*j+2] = init_board[src];
                end
                m++;
            end
        end
        for (int i = 0; i < int'(ROWS) - m; i++) exp_board[i] = '0;
        for (int i = 0; i < exp_n; i++) begin
            exp_wen[2*ROWS+1+i]   = 1'b1;
            exp_waddr[2*ROWS+1+i] = exp_n - 1 - i;
            exp_wdata[2*ROWS+1+i] = '0;
        end
        exp_done = 2 * int'(ROWS) + exp_n + 1;
    endtask

    task automatic load_board();
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        build_model();
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        m_total = 0;
        m_score = 0;
    endtask

    // One refresh with per-cycle comparison; optional stray refresh at cycle 5 or reset at cycle 10
    task automatic run_refresh(input bit poke5, input bit rst10);
        int inc;
        @(posedge clk); #1 refresh = 1'b1;
        @(posedge clk); #1 refresh = 1'b0;
        done_cyc = -1;
        for (int k = 1; k <= exp_done + 1; k++) begin
            @(negedge clk);
            if (rst10 && k == 10) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_wr_en", ram_wr_en, 0);
                chk("rst_done", refresh_done, 0);
                chk("rst_addr", ram_addr, 0);
                chk("rst_lines_last", lines_last, 0);
                chk("rst_score", score, 0);
                @(posedge clk); #1 rst = 1'b0;
                m_total = 0;
                m_score = 0;
                return;
            end
            if (poke5 && k == 5) refresh = 1'b1;
            if (poke5 && k == 6) refresh = 1'b0;
            if (refresh_done === 1'b1 && done_cyc < 0) done_cyc = k;
            chk("busy", busy, (k <= exp_done) ? 1 : 0);
            chk("refresh_done", refresh_done, (k == exp_done) ? 1 : 0);
            chk("wr_en", ram_wr_en, exp_wen[k]);
            if (exp_wen[k]) begin
                chk("wr_addr", ram_addr, exp_waddr[k]);
                chk("wr_data", ram_wr_data, exp_wdata[k]);
            end
        end
        case (exp_n)
            0: inc = 0; 1: inc = 1; 2: inc = 3; 3: inc = 5; default: inc = 8;
        endcase
        m_total = (m_total + exp_n) % 65536;
`ifdef LINE_CLEAR_SCORE_EN
        m_score = (m_score + inc > 65535) ? 65535 : m_score + inc;
`else
        m_score = 0;
`endif
        chk("done_cycle", done_cyc, exp_done);
        chk("lines_last", lines_last, exp_n);
        chk("lines_total", lines_total, m_total);
        chk("score", score, m_score);
        for (int i = 0; i < int'(ROWS); i++) chk("board_row", mem[i], exp_board[i]);
    endtask

    task automatic rand_board();
        for (int i = 0; i < int'(ROWS); i++)
            init_board[i] = ($urandom_range(0, 2) == 0) ? '1 : row_t'($urandom);
    endtask

    initial begin
        rst = 1'b1; refresh = 1'b0; load = 1'b0;
        for (int i = 0; i < int'(ROWS); i++) init_board[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", refresh_done, 0);
        chk("reset_wr_en", ram_wr_en, 0);
        chk("reset_addr", ram_addr, 0);
        chk("reset_wr_data", ram_wr_data, 0);
        chk("reset_lines_last", lines_last, 0);
        chk("reset_lines_total", lines_total, 0);
        chk("reset_score", score, 0);
        rst = 1'b0;

        // Empty board
        load_board();
        run_refresh(1'b0, 1'b0);
        chk("empty_done_lit", done_cyc, 41);
        chk("empty_lines_lit", lines_last, 0);

        // One full row at the bottom
        for (int i = 0; i < int'(ROWS); i++) init_board[i] = '0;
        init_board[19] = 10'h3FF; init_board[18] = 10'h155;
        load_board();
        run_refresh(1'b0, 1'b0);
        chk("one_done_lit", done_cyc, 42);
        chk("one_lines_lit", lines_last, 1);
        chk("one_row19_lit", mem[19], 10'h155);
`ifdef LINE_CLEAR_SCORE_EN
        chk("one_score_lit", score, 1);
`else
        chk("one_score_lit", score, 0);
`endif

        // Four full rows
        for (int i = 0; i < int'(ROWS); i++) init_board[i] = '0;
        for (int i = 16; i < 20; i++) init_board[i] = 10'h3FF;
        init_board[15] = 10'h0F0;
        load_board();
        run_refresh(1'b0, 1'b0);
        chk("four_lines_lit", lines_last, 4);
        chk("four_row19_lit", mem[19], 10'h0F0);

        // Interleaved full rows, counted from a fresh reset
        do_reset();
        for (int i = 0; i < int'(ROWS); i++) init_board[i] = '0;
        init_board[19] = 10'h3FF; init_board[17] = 10'h3FF;
        init_board[18] = 10'h00A; init_board[16] = 10'h0B0;
        load_board();
        run_refresh(1'b0, 1'b0);
        chk("two_row18_lit", mem[18], 10'h0B0);
        chk("two_total_lit", lines_total, 2);
`ifdef LINE_CLEAR_SCORE_EN
        chk("two_score_lit", score, 3);
`else
        chk("two_score_lit", score, 0);
`endif

        // Stray refresh while busy, then reset mid-scan and a clean rerun
        rand_board();
        load_board();
        run_refresh(1'b1, 1'b0);
        rand_board();
        load_board();
        run_refresh(1'b0, 1'b1);
        rand_board();
        load_board();
        run_refresh(1'b0, 1'b0);

        // Entirely full board
        for (int i = 0; i < int'(ROWS); i++) init_board[i] = '1;
        load_board();
        run_refresh(1'b0, 1'b0);
        chk("full_lines_lit", lines_last, 20);

        for (int t = 0; t < 25; t++) begin
            rand_board();
            load_board();
            run_refresh(1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
